keypad_event_queue: RTL and testbench

- Parametrised keypad front end that converts a raw one-hot keypad bus into a queue of debounced key-press events.
- Generalises the fixed 12-key input path: key count, debounce time and queue depth are parameters; adds multi-key rejection, a FIFO with overflow flag, and optional auto-repeat.
- Sits between the keypad pins and the entry/LCD control logic; the consumer pops one key code per accepted press.

---
 rtl/keypad_event_queue.sv | 197 +++++++++++++++++++
 tb/tb_keypad_event_queue.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/keypad_event_queue.sv
// Keypad front end: synchronise, debounce and reject multi-key samples, then queue key codes.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_event_queue #(
  parameter int NUM_KEYS     = 12,
  parameter int CODE_W       = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int DEPTH        = 8,
  parameter int REPEAT_CYC   = 256
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_KEYS-1:0]          keypad_in,
  input  logic                         pop,
  input  logic                         clr_overflow,
  output logic                         key_valid,
  output logic [CODE_W-1:0]            key_code,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0]     DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(DEPTH);
  localparam logic [NUM_KEYS-1:0] KEY_ONE = NUM_KEYS'(1);

  if ((2 ** CODE_W) < NUM_KEYS) begin : g_bad_code_w
    $error("CODE_W too small for NUM_KEYS");
  end
  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be >= 2");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (REPEAT_CYC < 1) begin : g_bad_repeat
    $error("REPEAT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_e;

  function automatic logic [CODE_W-1:0] encode_key(input logic [NUM_KEYS-1:0] oh);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (oh[i]) code = CODE_W'(i);
    end
    return code;
  endfunction

  logic [NUM_KEYS-1:0] sync1_q, s_key_q;
  state_e              state_q, state_d;
  logic [NUM_KEYS-1:0] cand_q, cand_d;
  logic [DB_W-1:0]     dcnt_q, dcnt_d;
  logic                key_onehot, same_key, push_req;
  logic [CODE_W-1:0]   push_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_CYC + 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYC - 1);
  logic [RP_W-1:0] rcnt_q, rcnt_d;
`endif

  // Two-flop synchroniser for the asynchronous key lines
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      s_key_q <= '0;
    end else begin
      sync1_q <= keypad_in;
      s_key_q <= sync1_q;
    end
  end

  assign key_onehot = (s_key_q != '0) && ((s_key_q & (s_key_q - KEY_ONE)) == '0);
  assign same_key   = (s_key_q == cand_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cand_q  <= '0;
      dcnt_q  <= '0;
`ifdef KEYPAD_REPEAT_EN
      rcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      dcnt_q  <= dcnt_d;
`ifdef KEYPAD_REPEAT_EN
      rcnt_q  <= rcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      IDLE: begin
        if (key_onehot) begin
          cand_d  = s_key_q;
          dcnt_d  = DB_W'(1);
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (same_key) begin
          dcnt_d = dcnt_q + DB_W'(1);
          if (dcnt_q == DB_LAST) state_d = HELD;
        end else begin
          state_d = IDLE;
        end
      end
      HELD: begin
        if (s_key_q == '0) begin
          dcnt_d  = DB_W'(1);
          state_d = REL_DB;
        end
      end
      REL_DB: begin
        if (s_key_q == '0) begin
          dcnt_d = dcnt_q + DB_W'(1);
          if (dcnt_q == DB_LAST) state_d = IDLE;
        end else begin
          state_d = HELD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  // rcnt restarts on every entry to HELD and whenever the held bit changes
  always_comb begin
    rcnt_d = '0;
    if ((state_q == HELD) && (state_d == HELD) && same_key) begin
      rcnt_d = (rcnt_q == RP_LAST) ? '0 : rcnt_q + RP_W'(1);
    end
  end
`endif

  always_comb begin
    push_req = (state_q == PRESS_DB) && same_key && (dcnt_q == DB_LAST);
`ifdef KEYPAD_REPEAT_EN
    push_req = push_req || ((state_q == HELD) && same_key && (rcnt_q == RP_LAST));
`endif
    push_code = encode_key(cand_q);
  end

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              do_pop, do_push;

  // A pop frees the slot in the same edge, so a full FIFO still accepts the push
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push_req && ((count_q != DEPTH_C) || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    ovf_d = ovf_q;
    if (push_req && !do_push) ovf_d = 1'b1;
    else if (clr_overflow)    ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_code;
  end

  assign key_valid = (count_q != '0);
  assign key_code  = key_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Scoreboard bench for keypad_event_queue (DEBOUNCE_CYC=4, DEPTH=4, REPEAT_CYC=16).
module tb_keypad_event_queue;
  localparam int DB    = 4;
  localparam int DEPTH = 4;
  localparam int RPT   = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] keypad_in = '0;
  logic        pop = 1'b0;
  logic        clr_overflow = 1'b0;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [2:0]  count;
  logic        full;
  logic        overflow;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  exp_q[$];
  logic        exp_ovf = 1'b0;

  keypad_event_queue #(
    .NUM_KEYS(12), .CODE_W(4), .DEBOUNCE_CYC(DB), .DEPTH(DEPTH), .REPEAT_CYC(RPT)
  ) dut (
    .clk(clk), .resetn(resetn), .keypad_in(keypad_in), .pop(pop),
    .clr_overflow(clr_overflow), .key_valid(key_valid), .key_code(key_code),
    .count(count), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_push(input logic [3:0] code);
    if (exp_q.size() < DEPTH) exp_q.push_back(code);
    else exp_ovf = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".count"}, 32'(count), 32'(exp_q.size()));
    check_eq({tag, ".valid"}, 32'(key_valid), 32'(exp_q.size() != 0));
    check_eq({tag, ".full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    check_eq({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
  endtask

  // Debounced single-key press: pushed to the scoreboard only if held long enough
  task automatic press_key(input int code, input int hold);
    keypad_in = 12'd1 << code;
    if (hold >= DB) model_push(4'(code));
    cycles(hold);
    keypad_in = '0;
    cycles(8);
  endtask

  task automatic press_raw(input logic [11:0] pat, input int hold);
    keypad_in = pat;
    cycles(hold);
    keypad_in = '0;
    cycles(8);
  endtask

  task automatic pop_check(input string tag);
    logic [3:0] exp_code;
    if (exp_q.size() == 0) begin
      check_eq({tag, ".empty"}, 32'(key_valid), 32'd0);
    end else begin
      exp_code = exp_q.pop_front();
      check_eq({tag, ".valid"}, 32'(key_valid), 32'd1);
      check_eq({tag, ".code"}, 32'(key_code), 32'(exp_code));
    end
    pop = 1'b1;
    cycles(1);
    pop = 1'b0;
  endtask

  initial begin
    logic [3:0] head;

    #1;
    check_state("reset_async");
    check_eq("reset.code", 32'(key_code), 32'd0);
    cycles(2);
    resetn = 1'b1;
    cycles(3);
    check_state("idle");
    check_eq("idle.code", 32'(key_code), 32'd0);

    // First press: exact push edge
    keypad_in = 12'h001;
    model_push(4'd0);
    cycles(DB + 1);
    check_eq("lat.before", 32'(key_valid), 32'd0);
    cycles(1);
    check_eq("lat.at", 32'(key_valid), 32'd1);
    check_eq("lat.code", 32'(key_code), 32'd0);
    cycles(4);
    keypad_in = '0;
    cycles(10);
    check_state("single");
    pop_check("pop1");

    // Bounce then stable press
    press_raw(12'h004, 2);
    check_state("bounce");
    press_key(2, 8);
    check_state("stable");
    pop_check("pop2");

    // Multi-key rejection, then '#'
    press_raw(12'hC01, 20);
    check_state("multi");
    press_key(11, 8);
    pop_check("pop_hash");

    // Overflow on the fifth press
    for (int k = 0; k < 5; k++) press_key(k, 8);
    check_state("fill5");
    for (int k = 0; k < 4; k++) pop_check("drain");
    check_state("drained");
    pop_check("pop_empty");
    check_state("after_empty_pop");
    clr_overflow = 1'b1;
    exp_ovf = 1'b0;
    cycles(1);
    clr_overflow = 1'b0;
    check_state("clr_ovf");

    // Push and pop on the same edge while full
    for (int k = 5; k < 9; k++) press_key(k, 8);
    check_state("full4");
    keypad_in = 12'd1 << 9;
    cycles(DB + 1);
    check_state("pre_push");
    head = exp_q.pop_front();
    check_eq("same.head", 32'(key_code), 32'(head));
    pop = 1'b1;
    cycles(1);
    pop = 1'b0;
    exp_q.push_back(4'd9);
    check_state("same_edge");
    cycles(4);
    keypad_in = '0;
    cycles(8);
    for (int k = 0; k < 4; k++) pop_check("tail");
    check_state("tail_empty");

    // Long hold of '0': repeats only with the optional feature
    keypad_in = 12'h400;
    model_push(4'd10);
`ifdef KEYPAD_REPEAT_EN
    model_push(4'd10);
    model_push(4'd10);
`endif
    cycles(DB + 40);
    keypad_in = '0;
    cycles(8);
    check_state("hold");
    while (exp_q.size() != 0) pop_check("hold_pop");
    check_state("hold_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
